// File: rtl/logic_op_pkg.sv
// Shared types and the reference bitwise-operation function for the logic op pipeline.
package logic_op_pkg;

    localparam int unsigned OP_W           = 3;
    localparam int unsigned LOGIC_OP_MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANDN   = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    // Operands are widened to LOGIC_OP_MAX_W; callers truncate the result to their width.
    function automatic logic [LOGIC_OP_MAX_W-1:0] logic_op_f(
        input op_e                       op,
        input logic [LOGIC_OP_MAX_W-1:0] a,
        input logic [LOGIC_OP_MAX_W-1:0] b
    );
        logic [LOGIC_OP_MAX_W-1:0] r;
        r = '0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_ANDN:   r = a & ~b;
            OP_PASS_A: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_pipe_if.sv
// Operand/result handshake bundle between a producer, the logic op pipeline and a consumer.
interface logic_op_pipe_if
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, z
    );

endinterface

// File: rtl/logic_op_stage.sv
// One pipeline slot: valid flag plus data word, loaded on i_load, cleared by reset.
module logic_op_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;

    // Data only updates when a real item arrives, so bubbles leave the word untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_load) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/logic_op_pipe.sv
// Selectable bitwise op on two operands, carried through a STAGES-deep valid/ready pipeline.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    logic_op_pipe_if.slave bus
);

    logic [WIDTH-1:0]  w_result;
    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_dat [STAGES];

    assign w_result = WIDTH'(logic_op_f(bus.op,
                                        LOGIC_OP_MAX_W'(bus.a),
                                        LOGIC_OP_MAX_W'(bus.b)));

    // Advance chain walked from the output back; a stage moves if it is empty or its successor moves.
    always_comb begin
        logic v_adv;
        w_adv = '0;
        v_adv = enable & ~rst & (~w_vld[STAGES-1] | bus.out_ready);
        w_adv[STAGES-1] = v_adv;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            v_adv    = enable & ~rst & (~w_vld[i] | v_adv);
            w_adv[i] = v_adv;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             w_in_vld;
        logic [WIDTH-1:0] w_in_dat;

        if (g == 0) begin : g_head
            assign w_in_vld = bus.in_valid;
            assign w_in_dat = w_result;
        end else begin : g_body
            assign w_in_vld = w_vld[g-1];
            assign w_in_dat = w_dat[g-1];
        end

        logic_op_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_adv[g]),
            .i_vld  (w_in_vld),
            .i_dat  (w_in_dat),
            .o_vld  (w_vld[g]),
            .o_dat  (w_dat[g])
        );
    end

    // Reset masks the outputs immediately, before the synchronous clear has taken effect.
    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = w_vld[STAGES-1] & enable & ~rst;
    assign bus.z         = rst ? '0 : w_dat[STAGES-1];

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe with a result scoreboard fed on accept and drained on output.
module tb_logic_op_pipe;
    import logic_op_pkg::*;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    always #5 clk = ~clk;

    logic_op_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_op_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    logic [WIDTH-1:0] exp_q  [$];
    logic [WIDTH-1:0] seen_q [$];
    int               seen_cyc [$];
    int               passed = 0;
    int               fails  = 0;
    int               total  = 0;
    int               cyc    = 0;

    function automatic logic [WIDTH-1:0] model(input op_e op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_ANDN:   r = a & ~b;
            default:   r = a;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Samples the handshakes for the current cycle, then advances to the next falling edge.
    task automatic tick(output logic acc);
        logic [WIDTH-1:0] e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (acc) exp_q.push_back(model(bus.op, bus.a, bus.b));
        if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("z_order", 32'(bus.z), 32'(e));
                seen_q.push_back(bus.z);
                seen_cyc.push_back(cyc);
            end
        end
        if (rst) exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(acc);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] nxt;
        int               n_acc;
        logic [WIDTH-1:0] exp8 [8];

        exp8[0] = 8'h0A; exp8[1] = 8'hAF; exp8[2] = 8'hA5; exp8[3] = 8'hF5;
        exp8[4] = 8'h50; exp8[5] = 8'h5A; exp8[6] = 8'hA0; exp8[7] = 8'hAA;

        // Reset held with a valid offer present
        rst           = 1'b1;
        enable        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = OP_OR;
        bus.a         = 8'hFF;
        bus.b         = 8'h11;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_z", 32'(bus.z), 32'd0);
            tick(acc);
        end

        // First transaction right after reset: AND F0,3C
        rst    = 1'b0;
        bus.op = OP_AND;
        bus.a  = 8'hF0;
        bus.b  = 8'h3C;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        tick(acc);
        bus.in_valid = 1'b0;
        #1;
        check("lat_cycle1_out_valid", 32'(bus.out_valid), 32'd0);
        tick(acc);
        #1;
        check("lat_cycle2_out_valid", 32'(bus.out_valid), 32'd1);
        check("and_z", 32'(bus.z), 32'h30);
        tick(acc);
        drain();

        // All eight ops streamed back to back
        seen_q.delete();
        seen_cyc.delete();
        bus.in_valid = 1'b1;
        bus.a        = 8'hAA;
        bus.b        = 8'h0F;
        for (int k = 0; k < 8; k++) begin
            bus.op = op_e'(3'(k));
            #1;
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick(acc);
        end
        drain();
        check("stream_count", 32'(seen_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < seen_q.size(); k++) begin
            check("stream_z", 32'(seen_q[k]), 32'(exp8[k]));
            if (k > 0) check("stream_spacing", 32'(seen_cyc[k] - seen_cyc[k-1]), 32'd1);
        end

        // Backpressure: out_ready low for 5 cycles with a continuous source
        bus.op        = OP_XOR;
        bus.b         = 8'h55;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        nxt           = 8'h10;
        n_acc         = 0;
        for (int k = 0; k < 5; k++) begin
            bus.a = nxt;
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'(k < 2));
            if (k >= 2) begin
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_z_stable", 32'(bus.z), 32'(exp_q[0]));
            end
            tick(acc);
            if (acc) begin
                nxt++;
                n_acc++;
            end
        end
        check("bp_accepts", 32'(n_acc), 32'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.a = nxt;
            tick(acc);
            if (acc) nxt++;
        end
        drain();

        // Freeze for 3 cycles mid-stream
        bus.in_valid = 1'b1;
        bus.op       = OP_NAND;
        bus.b        = 8'h0C;
        for (int k = 0; k < 3; k++) begin
            bus.a = nxt;
            tick(acc);
            if (acc) nxt++;
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.a = nxt;
            #1;
            check("frz_out_valid", 32'(bus.out_valid), 32'd0);
            check("frz_in_ready", 32'(bus.in_ready), 32'd0);
            check("frz_z_held", 32'(bus.z), 32'(exp_q[0]));
            tick(acc);
            if (acc) nxt++;
        end
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.a = nxt;
            tick(acc);
            if (acc) nxt++;
        end
        drain();

        // Reset pulse with two results in flight
        bus.in_valid = 1'b1;
        bus.op       = OP_OR;
        bus.b        = 8'h80;
        for (int k = 0; k < 2; k++) begin
            bus.a = nxt;
            tick(acc);
            nxt++;
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("pulse_out_valid", 32'(bus.out_valid), 32'd0);
        check("pulse_z", 32'(bus.z), 32'd0);
        check("pulse_in_ready", 32'(bus.in_ready), 32'd0);
        tick(acc);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = OP_NOR;
        bus.a        = 8'h12;
        bus.b        = 8'h34;
        #1;
        check("discard_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_pulse_in_ready", 32'(bus.in_ready), 32'd1);
        tick(acc);
        bus.in_valid = 1'b0;
        #1;
        check("pulse_lat1_out_valid", 32'(bus.out_valid), 32'd0);
        tick(acc);
        #1;
        check("pulse_lat2_out_valid", 32'(bus.out_valid), 32'd1);
        check("nor_z", 32'(bus.z), 32'hC9);
        tick(acc);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
